// File: rtl/multicycle_control_if.sv
// Control <-> datapath signal bundle for the multicycle MIPS control FSM.
// master = control unit, slave = datapath side.
interface multicycle_control_if;
  // Datapath status into the control unit
  logic [5:0] Opcode;
  logic       Zero;
  logic       Mem_Ready;

  // Control strobes and mux selects out to the datapath
  logic       PC_En;
  logic       IR_Write;
  logic       Mem_Read;
  logic       Mem_Write;
  logic       IorD;
  logic       Reg_Write;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       Illegal_Op;
  logic [3:0] State;

  modport master (
    input  Opcode, Zero, Mem_Ready,
    output PC_En, IR_Write, Mem_Read, Mem_Write, IorD, Reg_Write, RegDst,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Illegal_Op, State
  );

  modport slave (
    output Opcode, Zero, Mem_Ready,
    input  PC_En, IR_Write, Mem_Read, Mem_Write, IorD, Reg_Write, RegDst,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Illegal_Op, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core: fetch/decode/execute/mem/wb
// sequencing with memory wait-state stretching. Outputs are a Moore decode of
// the state register; PC_En/IR_Write are additionally gated by Mem_Ready/Zero.
module multicycle_control (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [SEL_W-1:0] SRCB_B     = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  state_t r_state;
  state_t w_next;
  logic   r_is_sw;

  // Opcode classification, only meaningful while in DECODE
  logic w_op_rtype;
  logic w_op_lw;
  logic w_op_sw;
  logic w_op_beq;
  logic w_op_addi;
  logic w_op_j;
  logic w_op_legal;

  assign w_op_rtype = (bus.Opcode == OP_RTYPE);
  assign w_op_lw    = (bus.Opcode == OP_LW);
  assign w_op_sw    = (bus.Opcode == OP_SW);
  assign w_op_beq   = (bus.Opcode == OP_BEQ);
  assign w_op_addi  = (bus.Opcode == OP_ADDI);
  assign w_op_j     = (bus.Opcode == OP_J);
  assign w_op_legal = w_op_rtype | w_op_lw | w_op_sw | w_op_beq | w_op_addi | w_op_j;

  // State register; async reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Remember lw vs sw at DECODE so MEMADR does not re-read the opcode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_sw <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_is_sw <= w_op_sw;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = bus.Mem_Ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_op_lw || w_op_sw) w_next = S_MEMADR;
        else if (w_op_rtype)    w_next = S_EXEC;
        else if (w_op_beq)      w_next = S_BEQ;
        else if (w_op_addi)     w_next = S_ADDIEX;
        else if (w_op_j)        w_next = S_JUMP;
        else                    w_next = S_FETCH;
      end
      S_MEMADR: w_next = r_is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = bus.Mem_Ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = bus.Mem_Ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BEQ:    w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  logic             w_pc_en;
  logic             w_ir_write;
  logic             w_mem_read;
  logic             w_mem_write;
  logic             w_iord;
  logic             w_reg_write;
  logic             w_regdst;
  logic             w_memtoreg;
  logic             w_alusrca;
  logic [SEL_W-1:0] w_alusrcb;
  logic [SEL_W-1:0] w_aluop;
  logic [SEL_W-1:0] w_pcsrc;
  logic             w_illegal_op;

  // Output decode; reset masks every write/load strobe in the same cycle
  always_comb begin
    w_pc_en      = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_iord       = 1'b0;
    w_reg_write  = 1'b0;
    w_regdst     = 1'b0;
    w_memtoreg   = 1'b0;
    w_alusrca    = 1'b0;
    w_alusrcb    = SRCB_B;
    w_aluop      = ALUOP_ADD;
    w_pcsrc      = PCSRC_ALU;
    w_illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_alusrcb  = SRCB_FOUR;
        w_ir_write = bus.Mem_Ready;
        w_pc_en    = bus.Mem_Ready;
      end
      S_DECODE: begin
        w_alusrcb    = SRCB_IMMSH;
        w_illegal_op = ~w_op_legal;
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write = 1'b1;
        w_memtoreg  = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
      end
      S_EXEC: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_regdst    = 1'b1;
      end
      S_BEQ: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_SUB;
        w_pcsrc   = PCSRC_ALUOUT;
        w_pc_en   = bus.Zero;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_IMM;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc = PCSRC_JUMP;
        w_pc_en = 1'b1;
      end
      default: begin
        w_pc_en = 1'b0;
      end
    endcase
    if (rst) begin
      w_pc_en      = 1'b0;
      w_ir_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_write  = 1'b0;
      w_illegal_op = 1'b0;
    end
  end

  assign bus.PC_En      = w_pc_en;
  assign bus.IR_Write   = w_ir_write;
  assign bus.Mem_Read   = w_mem_read;
  assign bus.Mem_Write  = w_mem_write;
  assign bus.IorD       = w_iord;
  assign bus.Reg_Write  = w_reg_write;
  assign bus.RegDst     = w_regdst;
  assign bus.MemtoReg   = w_memtoreg;
  assign bus.ALUSrcA    = w_alusrca;
  assign bus.ALUSrcB    = w_alusrcb;
  assign bus.ALUOp      = w_aluop;
  assign bus.PCSrc      = w_pcsrc;
  assign bus.Illegal_Op = w_illegal_op;
  assign bus.State      = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// instruction streams, compared cycle by cycle against an instruction-level model.
module tb_multicycle_control;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_J    = 6'b000010;

  function automatic bit is_legal(input logic [5:0] op);
    return op == OPC_R || op == OPC_LW || op == OPC_SW || op == OPC_BEQ ||
           op == OPC_ADDI || op == OPC_J;
  endfunction

  // {PC_En,IR_Write,Mem_Read,Mem_Write,IorD,Reg_Write,RegDst,MemtoReg,
  //  ALUSrcA,ALUSrcB,ALUOp,PCSrc,Illegal_Op}
  function automatic logic [15:0] observed();
    return {bus.PC_En, bus.IR_Write, bus.Mem_Read, bus.Mem_Write, bus.IorD,
            bus.Reg_Write, bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB,
            bus.ALUOp, bus.PCSrc, bus.Illegal_Op};
  endfunction

  // Expected control word from the per-state rules, by set membership
  function automatic logic [15:0] expected(input int s, input bit rdy, input bit z,
                                           input logic [5:0] op);
    logic       pc_en, ir_wr, mrd, mwr, iord, rwr, rdst, m2r, srca, ill;
    logic [1:0] srcb, aop, psrc;
    pc_en = (s == 0 && rdy) || (s == 8 && z) || (s == 11);
    ir_wr = (s == 0 && rdy);
    mrd   = (s == 0 || s == 3);
    mwr   = (s == 5);
    iord  = (s == 3 || s == 5);
    rwr   = (s == 4 || s == 7 || s == 10);
    rdst  = (s == 7);
    m2r   = (s == 4);
    srca  = (s == 2 || s == 6 || s == 8 || s == 9);
    srcb  = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : (s == 2 || s == 9) ? 2'b10 : 2'b00;
    aop   = (s == 6) ? 2'b10 : (s == 8) ? 2'b01 : 2'b00;
    psrc  = (s == 8) ? 2'b01 : (s == 11) ? 2'b10 : 2'b00;
    ill   = (s == 1) && !is_legal(op);
    return {pc_en, ir_wr, mrd, mwr, iord, rwr, rdst, m2r, srca, srcb, aop, psrc, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction from FETCH back to FETCH, with wait states, checked each cycle
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit z,
                           input string tag);
    int seq[$];
    bit rdy[$];
    for (int i = 0; i < fw; i++) begin seq.push_back(0); rdy.push_back(1'b0); end
    seq.push_back(0); rdy.push_back(1'b1);
    seq.push_back(1); rdy.push_back(1'($urandom));
    if (op == OPC_LW || op == OPC_SW) begin
      int ms = (op == OPC_LW) ? 3 : 5;
      seq.push_back(2); rdy.push_back(1'($urandom));
      for (int i = 0; i < mw; i++) begin seq.push_back(ms); rdy.push_back(1'b0); end
      seq.push_back(ms); rdy.push_back(1'b1);
      if (op == OPC_LW) begin seq.push_back(4); rdy.push_back(1'($urandom)); end
    end else if (op == OPC_R) begin
      seq.push_back(6); rdy.push_back(1'($urandom));
      seq.push_back(7); rdy.push_back(1'($urandom));
    end else if (op == OPC_ADDI) begin
      seq.push_back(9);  rdy.push_back(1'($urandom));
      seq.push_back(10); rdy.push_back(1'($urandom));
    end else if (op == OPC_BEQ) begin
      seq.push_back(8); rdy.push_back(1'($urandom));
    end else if (op == OPC_J) begin
      seq.push_back(11); rdy.push_back(1'($urandom));
    end
    for (int k = 0; k < seq.size(); k++) begin
      logic [5:0] drv_op;
      bit         drv_z;
      @(negedge clk);
      drv_op = (seq[k] == 0) ? 6'($urandom) : op;
      drv_z  = (seq[k] == 8) ? z : 1'($urandom);
      bus.Mem_Ready = rdy[k];
      bus.Opcode    = drv_op;
      bus.Zero      = drv_z;
      #1;
      chk({tag, "_state"}, 32'(bus.State), 32'(seq[k]));
      chk({tag, "_ctrl"}, 32'(observed()), 32'(expected(seq[k], rdy[k], drv_z, drv_op)));
    end
    // Next cycle must be a fresh FETCH; hold it with Mem_Ready low
    @(negedge clk);
    bus.Mem_Ready = 1'b0;
    #1;
    chk({tag, "_ret"}, 32'(bus.State), 32'd0);
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] rop;
    checks = 0;
    errors = 0;
    ops[0] = OPC_R; ops[1] = OPC_LW; ops[2] = OPC_SW;
    ops[3] = OPC_BEQ; ops[4] = OPC_ADDI; ops[5] = OPC_J;

    rst = 1'b1;
    bus.Opcode = 6'd0;
    bus.Zero = 1'b0;
    bus.Mem_Ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", 32'(bus.State), 32'd0);
    chk("rst_ctrl", 32'(observed()), 32'(expected(0, 1'b0, 1'b0, 6'd0)));
    bus.Mem_Ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait opcode sequence
    run_instr(OPC_LW,   0, 0, 1'b0, "lw0");
    run_instr(OPC_SW,   0, 0, 1'b0, "sw0");
    run_instr(OPC_R,    0, 0, 1'b0, "r0");
    run_instr(OPC_ADDI, 0, 0, 1'b0, "addi0");
    run_instr(OPC_J,    0, 0, 1'b0, "j0");
    // Branch taken and not taken
    run_instr(OPC_BEQ,  0, 0, 1'b1, "beq_t");
    run_instr(OPC_BEQ,  0, 0, 1'b0, "beq_nt");
    // lw with 3 fetch waits and 2 MEMRD waits: 10 cycles
    run_instr(OPC_LW,   3, 2, 1'b0, "lw_wait");
    run_instr(OPC_SW,   1, 3, 1'b0, "sw_wait");
    // Illegal opcode
    run_instr(6'b111111, 0, 0, 1'b0, "illegal");

    // Reset during a stalled MEMWR
    @(negedge clk); bus.Mem_Ready = 1'b1; bus.Opcode = OPC_SW;
    @(negedge clk); bus.Mem_Ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("pre_rst_state", 32'(bus.State), 32'd5);
    chk("pre_rst_mwr", 32'(bus.Mem_Write), 32'd1);
    rst = 1'b1;
    bus.Mem_Ready = 1'b1;
    #1;
    chk("mid_rst_state", 32'(bus.State), 32'd0);
    chk("mid_rst_mwr", 32'(bus.Mem_Write), 32'd0);
    chk("mid_rst_pcen", 32'(bus.PC_En), 32'd0);
    chk("mid_rst_irw", 32'(bus.IR_Write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.Opcode = OPC_J;
    #1;
    chk("post_rst_pcen", 32'(bus.PC_En), 32'd1);
    chk("post_rst_irw", 32'(bus.IR_Write), 32'd1);
    @(negedge clk); #1;
    chk("post_rst_decode", 32'(bus.State), 32'd1);
    @(negedge clk); #1;
    chk("post_rst_jump", 32'(bus.State), 32'd11);
    chk("post_rst_jpcen", 32'(bus.PC_En), 32'd1);
    bus.Mem_Ready = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_fetch", 32'(bus.State), 32'd0);

    // Random instruction stream
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        rop = 6'($urandom);
        if (is_legal(rop)) rop = 6'b111110;
      end else begin
        rop = ops[$urandom_range(0, 5)];
      end
      run_instr(rop, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
